// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the switch debouncer.
`timescale 1ns/1ps
package debouncer_pkg;
    localparam int DEB_N_MAX_DEFAULT       = 50;
    localparam int DEB_SYNC_STAGES_DEFAULT = 2;

    // Counter must hold 0..N_MAX without wrapping.
    function automatic int deb_cnt_width(input int n_max);
        return $clog2(n_max + 1);
    endfunction
endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; flops clear on reset.
`timescale 1ns/1ps
module sync_ff_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst_a_p) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end

    assign q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/debouncer.sv
// Switch debouncer: synchronize, then accept a new level after N_MAX stable cycles.
// Optional one-cycle edge pulses are enabled with DEBOUNCER_EDGE_PULSE_EN.
`timescale 1ns/1ps
module debouncer
    import debouncer_pkg::*;
#(
    parameter int N_MAX       = DEB_N_MAX_DEFAULT,
    parameter int SYNC_STAGES = DEB_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_a_p,
    input  logic debouncer_in,
`ifdef DEBOUNCER_EDGE_PULSE_EN
    output logic rise_pulse,
    output logic fall_pulse,
`endif
    output logic debouncer_out
);
    localparam int               CNT_W    = deb_cnt_width(N_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MAX - 1);

    logic             w_in_s;
    logic             w_flip;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;

    sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .d       (debouncer_in),
        .q       (w_in_s)
    );

    // Output takes the new level on the edge that completes the stable run.
    assign w_flip = (w_in_s != r_out) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (w_in_s == r_out) begin
            r_cnt <= '0;
        end else if (w_flip) begin
            r_out <= w_in_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign debouncer_out = r_out;

`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_flip &  w_in_s;
            r_fall <= w_flip & ~w_in_s;
        end
    end

    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
`endif
endmodule

// File: tb/tb_debouncer.sv
// Directed self-checking bench for debouncer (N_MAX=50, SYNC_STAGES=2, 20 ns clock).
`timescale 1ns/1ps
module tb_debouncer;
    localparam int N   = 50;
    localparam int S   = 2;
    localparam int LAT = S + N;

    logic clk = 1'b0;
    logic rst_a_p = 1'b1;
    logic din = 1'b0;
    logic dout;
`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic rp;
    logic fp;
`endif

    int errs   = 0;
    int checks = 0;

    always #10 clk = ~clk;

    debouncer #(.N_MAX(N), .SYNC_STAGES(S)) dut (
        .clk           (clk),
        .rst_a_p       (rst_a_p),
        .debouncer_in  (din),
`ifdef DEBOUNCER_EDGE_PULSE_EN
        .rise_pulse    (rp),
        .fall_pulse    (fp),
`endif
        .debouncer_out (dout)
    );

    // Inputs change 1 ns after an edge; the next edge is the first to sample them.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp;
        rst_a_p = 1'b1;
        din     = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (dout !== 1'b0) begin
                errs++;
                $display("FAIL reset_hold cyc=%0d out=%b exp=0", i, dout);
            end
`ifdef DEBOUNCER_EDGE_PULSE_EN
            checks++;
            if (rp !== 1'b0 || fp !== 1'b0) begin
                errs++;
                $display("FAIL reset_pulse cyc=%0d rise=%b fall=%b exp=0/0", i, rp, fp);
            end
`endif
        end
        rst_a_p = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            exp = (i == LAT);
            checks++;
            if (dout !== exp) begin
                errs++;
                $display("FAIL reset_release edge=%0d out=%b exp=%b", i, dout, exp);
            end
        end
    endtask

    task automatic test_bounce_release();
        int   w[6] = '{1, 2, 2, 1, 1, 2};
        logic v;
        logic exp;
        v = 1'b0;
        for (int k = 0; k < 6; k++) begin
            din = v;
            for (int j = 0; j < w[k]; j++) begin
                tick();
                checks++;
                if (dout !== 1'b1) begin
                    errs++;
                    $display("FAIL release_bounce seg=%0d out=%b exp=1", k, dout);
                end
            end
            v = ~v;
        end
        din = 1'b0;
        for (int i = 1; i <= LAT + 3; i++) begin
            tick();
            exp = (i < LAT);
            checks++;
            if (dout !== exp) begin
                errs++;
                $display("FAIL release_settle edge=%0d out=%b exp=%b", i, dout, exp);
            end
`ifdef DEBOUNCER_EDGE_PULSE_EN
            checks++;
            if (fp !== (i == LAT) || rp !== 1'b0) begin
                errs++;
                $display("FAIL release_pulse edge=%0d fall=%b rise=%b exp=%b/0", i, fp, rp, (i == LAT));
            end
`endif
        end
    endtask

    task automatic test_bounce_press();
        int   w[6] = '{2, 1, 3, 2, 1, 3};
        logic v;
        logic exp;
        v = 1'b1;
        for (int k = 0; k < 6; k++) begin
            din = v;
            for (int j = 0; j < w[k]; j++) begin
                tick();
                checks++;
                if (dout !== 1'b0) begin
                    errs++;
                    $display("FAIL press_bounce seg=%0d out=%b exp=0", k, dout);
                end
            end
            v = ~v;
        end
        din = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            tick();
            exp = (i >= LAT);
            checks++;
            if (dout !== exp) begin
                errs++;
                $display("FAIL press_settle edge=%0d out=%b exp=%b", i, dout, exp);
            end
`ifdef DEBOUNCER_EDGE_PULSE_EN
            checks++;
            if (rp !== (i == LAT) || fp !== 1'b0) begin
                errs++;
                $display("FAIL press_pulse edge=%0d rise=%b fall=%b exp=%b/0", i, rp, fp, (i == LAT));
            end
`endif
        end
    endtask

    task automatic test_glitch();
        logic exp;
        // Bring output back to 0 via reset; reset must not emit a fall pulse.
        rst_a_p = 1'b1;
        din     = 1'b0;
        tick();
        checks++;
        if (dout !== 1'b0) begin
            errs++;
            $display("FAIL glitch_reset out=%b exp=0", dout);
        end
`ifdef DEBOUNCER_EDGE_PULSE_EN
        checks++;
        if (fp !== 1'b0) begin
            errs++;
            $display("FAIL glitch_reset_pulse fall=%b exp=0", fp);
        end
`endif
        rst_a_p = 1'b0;
        repeat (4) tick();
        for (int i = 1; i <= 110; i++) begin
            din = (i <= N - 1);
            tick();
            checks++;
            if (dout !== 1'b0) begin
                errs++;
                $display("FAIL glitch_49 edge=%0d out=%b exp=0", i, dout);
            end
        end
        for (int i = 1; i <= 110; i++) begin
            din = (i <= N);
            tick();
            exp = (i >= LAT) && (i < LAT + N);
            checks++;
            if (dout !== exp) begin
                errs++;
                $display("FAIL glitch_50 edge=%0d out=%b exp=%b", i, dout, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        din = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (dout !== 1'b0) begin
                errs++;
                $display("FAIL mid_precount cyc=%0d out=%b exp=0", i, dout);
            end
        end
        rst_a_p = 1'b1;
        tick();
        rst_a_p = 1'b0;
        for (int i = 1; i <= LAT + 2; i++) begin
            tick();
            exp = (i >= LAT);
            checks++;
            if (dout !== exp) begin
                errs++;
                $display("FAIL mid_restart edge=%0d out=%b exp=%b", i, dout, exp);
            end
`ifdef DEBOUNCER_EDGE_PULSE_EN
            checks++;
            if (rp !== (i == LAT)) begin
                errs++;
                $display("FAIL mid_pulse edge=%0d rise=%b exp=%b", i, rp, (i == LAT));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_bounce_release();
        test_bounce_press();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
